// File: rtl/avg_encode.sv
// AVG vector-list assembler: one drawing command in,
// one or two encoded words out to vector RAM.
module avg_encode #(
  parameter int ADDR_W  = 11,
  parameter bit SVEC_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [12:0]       cmd_dx,
  input  logic [12:0]       cmd_dy,
  input  logic [2:0]        cmd_z,
  input  logic [3:0]        cmd_intens,
  input  logic [2:0]        cmd_color,
  input  logic [7:0]        cmd_lin,
  input  logic [2:0]        cmd_bin,
  input  logic [11:0]       cmd_target,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W:0]   words,
  output logic              halted,
  output logic              overflow
);

  typedef enum logic [2:0] {
    IDLE, READY, WORD1, DONE, ERR
  } state_t;

  localparam logic [2:0] OP_VEC  = 3'd0;
  localparam logic [2:0] OP_HALT = 3'd1;
  localparam logic [2:0] OP_STAT = 3'd2;
  localparam logic [2:0] OP_SCAL = 3'd3;
  localparam logic [2:0] OP_CNTR = 3'd4;
  localparam logic [2:0] OP_JSR  = 3'd5;
  localparam logic [2:0] OP_RTS  = 3'd6;
  localparam logic [2:0] OP_JMP  = 3'd7;

  // One past the last legal word; the write pointer may reach it
  // but never wraps, so it carries one extra bit.
  localparam logic [ADDR_W+1:0] LIM =
    (ADDR_W+2)'(1) << ADDR_W;
  localparam logic [ADDR_W+1:0] N1 = (ADDR_W+2)'(1);
  localparam logic [ADDR_W+1:0] N2 = (ADDR_W+2)'(2);
  localparam logic [ADDR_W:0]   P1 = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   vptr_q, vptr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              halted_q, halted_d;
  logic              ovf_q, ovf_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [15:0]       w1_q, w1_d;

  logic        dx_short, dy_short, use_svec;
  logic        two;
  logic [15:0] w0, w1;
  logic        fits;

  // Short form needs even deltas inside -32..30.
  assign dx_short = ~cmd_dx[0] &
    ((&cmd_dx[12:5]) | ~(|cmd_dx[12:5]));
  assign dy_short = ~cmd_dy[0] &
    ((&cmd_dy[12:5]) | ~(|cmd_dy[12:5]));
  assign use_svec = SVEC_EN & dx_short & dy_short;
  assign two = (cmd_op == OP_VEC) & ~use_svec;

  // Encode the command into its first (and optional second) word.
  always_comb begin
    w0 = 16'h0000;
    w1 = {cmd_z, cmd_dx};
    unique case (cmd_op)
      OP_VEC:
        w0 = use_svec
          ? {3'b010, cmd_dy[5:1], cmd_z, cmd_dx[5:1]}
          : {3'b000, cmd_dy};
      OP_HALT: w0 = 16'h2000;
      OP_STAT:
        w0 = {3'b011, 2'b00, cmd_color,
              cmd_intens, 4'h0};
      OP_SCAL:
        w0 = {3'b011, 1'b1, 1'b0, cmd_bin, cmd_lin};
      OP_CNTR: w0 = 16'h8000;
      OP_JSR:  w0 = {3'b101, 1'b0, cmd_target};
      OP_RTS:  w0 = 16'hC000;
      OP_JMP:  w0 = {3'b111, 1'b0, cmd_target};
    endcase
  end

  assign fits =
    ({1'b0, vptr_q} + (two ? N2 : N1)) <= LIM;

  assign cmd_ready = (state_q == READY) & ~start;

  // Next-state: start overrides everything, then per-state work.
  always_comb begin
    state_d   = state_q;
    vptr_d    = vptr_q;
    words_d   = words_q;
    halted_d  = halted_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    w1_d      = w1_q;
    if (start) begin
      state_d  = READY;
      vptr_d   = {1'b0, base_addr};
      words_d  = '0;
      halted_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        READY: begin
          if (cmd_valid) begin
            if (!fits) begin
              ovf_d   = 1'b1;
              state_d = ERR;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = vptr_q[ADDR_W-1:0];
              wr_data_d = w0;
              vptr_d    = vptr_q + P1;
              words_d   = words_q + P1;
              if (two) begin
                w1_d    = w1;
                state_d = WORD1;
              end else if (cmd_op == OP_HALT) begin
                halted_d = 1'b1;
                state_d  = DONE;
              end
            end
          end
        end
        WORD1: begin
          wr_en_d   = 1'b1;
          wr_addr_d = vptr_q[ADDR_W-1:0];
          wr_data_d = w1_q;
          vptr_d    = vptr_q + P1;
          words_d   = words_q + P1;
          state_d   = READY;
        end
        IDLE, DONE, ERR: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vptr_q    <= '0;
      words_q   <= '0;
      halted_q  <= 1'b0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      w1_q      <= '0;
    end else begin
      state_q   <= state_d;
      vptr_q    <= vptr_d;
      words_q   <= words_d;
      halted_q  <= halted_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      w1_q      <= w1_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign ptr      = vptr_q[ADDR_W] ? '1
                                   : vptr_q[ADDR_W-1:0];
  assign words    = words_q;
  assign halted   = halted_q;
  assign overflow = ovf_q;

endmodule
